stepper_ramp: RTL and testbench
===============================

// Module: stepper_ramp
// PURPOSE
//  Command generator that sits directly upstream of the stepper phase driver: it produces its 32-bit command word
//  and one-cycle new_data strobe. It takes a target half-step period and run request from the processor bus.
//  It ramps the period linearly between slow and fast limits, so the motor never jumps speed.
//  It also raises both bridge enables on start and drops them only after decelerating to the slow limit.
// PARAMETERS
//  PERIOD_FAST  263158   minimum half-step period (clocks), fastest speed
//  PERIOD_SLOW  1000000  maximum half-step period (clocks), start/stop speed
//  RAMP_DIV     1000000  clocks per ramp tick (10 ms @100 MHz), >=2
//  RAMP_STEP    20000    max period change per ramp tick, >0
// PORTS
//  CLK100MHZ   in   1   system clock
//  CPU_RESETN  in   1   asynchronous active-low reset
//  wr_en       in   1   one-cycle write strobe from processor
//  wr_data     in   32  [21:0] target period, [22] run request, [31:23] ignored
//  cmd_data    out  32  {8'h00, en, en, cur_period[21:0]}; feeds driver data_in
//  cmd_valid   out  1   one-cycle pulse, drives driver new_data
//  busy        out  1   high in RAMP or STOP
// BEHAVIOUR
//  Reset (async): state=IDLE, cur_period=PERIOD_SLOW, en=0, tgt=PERIOD_SLOW, run=0, ramp_cnt=0,
//   cmd_valid=0, busy=0, cmd_data=32'h000F4240 (defaults). No strobe is issued on reset release.
//  Write: on wr_en, tgt <= clamp(wr_data[21:0]) to [PERIOD_FAST,PERIOD_SLOW] and run <= wr_data[22].
//   New values are visible from the next cycle.
//  cmd_data and cmd_valid update on the same edge. cmd_valid is high exactly one cycle, and only when cmd_data changed.
//   cmd_data holds between strobes.
//  ramp_cnt counts 0..RAMP_DIV-1 in RAMP/STOP and is cleared on every state entry. A tick occurs when ramp_cnt==RAMP_DIV-1.
//  Tick update: cur moves toward goal by min(RAMP_STEP, |cur-goal|), with strobe.
//   Compare first, then subtract: 22-bit unsigned, never wraps.
//  States:
//   IDLE : en=0. If run=1: en<=1, cur=PERIOD_SLOW, strobe next cycle, goto RAMP.
//   RAMP : goal=tgt. On tick, step. When cur==tgt after a step, or on entry, goto HOLD.
//          If run=0, goto STOP.
//   HOLD : no strobes. If run=0, goto STOP. If tgt!=cur after a write, goto RAMP.
//   STOP : goal=PERIOD_SLOW. On tick, step. When cur==PERIOD_SLOW: en<=0, strobe, goto IDLE.
//          If run=1 again, goto RAMP; en stays 1.
//  A write in IDLE with run=0 updates tgt only: no strobe, no state change.
//  wr_en on a tick cycle: the tick uses the old tgt/run, and the new values apply from the next cycle.
//  A target change mid-RAMP, including a direction reversal, redirects the ramp at the next tick.
//   Counter phase is unaffected.
//  Reset asserted mid-ramp forces reset values immediately. Any in-flight strobe is lost.
// CONFIGURATION
//  STEPPER_RAMP_ECHO_CHECK_EN defined: adds cmd_echo (in, 32, driver data_out) and echo_err (out, 1).
//   In the cycle after each cmd_valid, if cmd_echo!=cmd_data, echo_err<=1.
//   echo_err is sticky and cleared by wr_en or reset; reset value is 0.
//  Not defined: both ports and all check logic are absent; behaviour is otherwise identical.
// TESTING (bench overrides RAMP_DIV=4, RAMP_STEP=100000)
//  1 Reset held then released -> cmd_data=32'h000F4240, cmd_valid=0, busy=0, with no strobe for 20 cycles.
//  2 Write run=1, period 600000 -> next cycle strobe with cmd_data=32'h00CF4240.
//    Then one strobe per 4 clocks: 900000, 800000, 700000, 600000; then HOLD, busy=0.
//  3 From HOLD@600000, write run=1, period 100 -> clamp to 263158.
//    Strobes: 500000, 400000, 300000, 263158; then no further strobes.
//  4 From HOLD@600000, write run=0 -> strobes 700000..1000000.
//    Then strobe with cmd_data=32'h000F4240 (en=0), state IDLE.
//  5 During STOP at 800000, write run=1, period 600000 -> strobes 700000, 600000.
//    Bits [23:22] stay 2'b11 throughout.
//  6 With the macro, force cmd_echo=0 after a strobe -> echo_err=1 the cycle after; a subsequent wr_en clears it.
//    Also assert CPU_RESETN low mid-ramp -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/stepper_ramp.sv
// stepper_ramp: linear half-step period ramp generator feeding the stepper phase driver.
// Optional readback check of the driver's echoed command word: define STEPPER_RAMP_ECHO_CHECK_EN.
module stepper_ramp #(
    parameter int unsigned PERIOD_FAST = 263158,
    parameter int unsigned PERIOD_SLOW = 1000000,
    parameter int unsigned RAMP_DIV    = 1000000,
    parameter int unsigned RAMP_STEP   = 20000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
`ifdef STEPPER_RAMP_ECHO_CHECK_EN
    input  logic [31:0] cmd_echo,
    output logic        echo_err,
`endif
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    output logic        busy
);

    localparam int unsigned CW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [21:0]   FAST     = 22'(PERIOD_FAST);
    localparam logic [21:0]   SLOW     = 22'(PERIOD_SLOW);
    localparam logic [21:0]   STEP     = 22'(RAMP_STEP);
    localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t        state;
    logic [21:0]   cur;
    logic [21:0]   tgt;
    logic          run;
    logic          en;
    logic [CW-1:0] ramp_cnt;

    logic          tick;
    logic [21:0]   wr_period;
    logic [21:0]   tgt_in;
    logic [21:0]   step_ramp;
    logic [21:0]   step_stop;
    logic          unused_bits;

    assign unused_bits = ^wr_data[31:23];

    // Magnitude is compared before subtracting so the 22-bit result never wraps.
    function automatic logic [21:0] step_toward(input logic [21:0] val, input logic [21:0] goal);
        logic [21:0] diff;
        if (val > goal) begin
            diff = val - goal;
            return (diff > STEP) ? (val - STEP) : goal;
        end else begin
            diff = goal - val;
            return (diff > STEP) ? (val + STEP) : goal;
        end
    endfunction

    function automatic logic [31:0] pack(input logic bridge_en, input logic [21:0] period);
        return {8'h00, bridge_en, bridge_en, period};
    endfunction

    always_comb begin
        wr_period = wr_data[21:0];
        if (wr_period < FAST)
            tgt_in = FAST;
        else if (wr_period > SLOW)
            tgt_in = SLOW;
        else
            tgt_in = wr_period;
        tick      = (ramp_cnt == CNT_LAST);
        step_ramp = step_toward(cur, tgt);
        step_stop = step_toward(cur, SLOW);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state     <= IDLE;
            cur       <= SLOW;
            tgt       <= SLOW;
            run       <= 1'b0;
            en        <= 1'b0;
            ramp_cnt  <= '0;
            cmd_data  <= pack(1'b0, SLOW);
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (wr_en) begin
                tgt <= tgt_in;
                run <= wr_data[22];
            end
            case (state)
                IDLE: begin
                    ramp_cnt <= '0;
                    if (run) begin
                        en        <= 1'b1;
                        cur       <= SLOW;
                        cmd_data  <= pack(1'b1, SLOW);
                        cmd_valid <= 1'b1;
                        state     <= RAMP;
                        busy      <= 1'b1;
                    end
                end
                RAMP: begin
                    if (!run) begin
                        state    <= STOP;
                        ramp_cnt <= '0;
                    end else if (cur == tgt) begin
                        state    <= HOLD;
                        busy     <= 1'b0;
                        ramp_cnt <= '0;
                    end else if (tick) begin
                        cur       <= step_ramp;
                        cmd_data  <= pack(en, step_ramp);
                        cmd_valid <= 1'b1;
                        ramp_cnt  <= '0;
                        if (step_ramp == tgt) begin
                            state <= HOLD;
                            busy  <= 1'b0;
                        end
                    end else begin
                        ramp_cnt <= ramp_cnt + CW'(1);
                    end
                end
                HOLD: begin
                    ramp_cnt <= '0;
                    if (!run) begin
                        state <= STOP;
                        busy  <= 1'b1;
                    end else if (tgt != cur) begin
                        state <= RAMP;
                        busy  <= 1'b1;
                    end
                end
                STOP: begin
                    if (run) begin
                        state    <= RAMP;
                        ramp_cnt <= '0;
                    end else if (cur == SLOW) begin
                        // Final strobe only drops the bridge enables; the period is already slow.
                        en        <= 1'b0;
                        cmd_data  <= pack(1'b0, cur);
                        cmd_valid <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        ramp_cnt  <= '0;
                    end else if (tick) begin
                        cur       <= step_stop;
                        cmd_data  <= pack(en, step_stop);
                        cmd_valid <= 1'b1;
                        ramp_cnt  <= '0;
                    end else begin
                        ramp_cnt <= ramp_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ramp_cnt <= '0;
                end
            endcase
        end
    end

`ifdef STEPPER_RAMP_ECHO_CHECK_EN
    // cmd_valid is high during the cycle after the strobe edge, when the echo is compared.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN)
            echo_err <= 1'b0;
        else if (wr_en)
            echo_err <= 1'b0;
        else if (cmd_valid && (cmd_echo != cmd_data))
            echo_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_stepper_ramp.sv
// Directed testbench for stepper_ramp with RAMP_DIV=4, RAMP_STEP=100000.
module tb_stepper_ramp;

    logic        CLK100MHZ = 1'b0;
    logic        CPU_RESETN = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        busy;
    int          total = 0;
    int          bad = 0;

`ifdef STEPPER_RAMP_ECHO_CHECK_EN
    logic [31:0] cmd_echo;
    logic        echo_err;
    logic        echo_bad = 1'b0;
    assign cmd_echo = echo_bad ? 32'h0 : cmd_data;
`endif

    always #5 CLK100MHZ = ~CLK100MHZ;

    stepper_ramp #(
        .PERIOD_FAST(263158),
        .PERIOD_SLOW(1000000),
        .RAMP_DIV   (4),
        .RAMP_STEP  (100000)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESETN(CPU_RESETN),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
`ifdef STEPPER_RAMP_ECHO_CHECK_EN
        .cmd_echo  (cmd_echo),
        .echo_err  (echo_err),
`endif
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .busy      (busy)
    );

    function automatic logic [31:0] word(input logic e, input int unsigned p);
        logic [21:0] p22;
        p22 = 22'(p);
        return {8'h00, e, e, p22};
    endfunction

    task automatic write(input logic run_b, input int unsigned period);
        logic [21:0] p22;
        p22 = 22'(period);
        @(negedge CLK100MHZ);
        wr_en   = 1'b1;
        wr_data = {9'h0, run_b, p22};
        @(negedge CLK100MHZ);
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic get_strobe(input int max_cyc, output logic [31:0] data, output int cyc, output bit got);
        got  = 1'b0;
        data = '0;
        cyc  = 0;
        while (!got && cyc < max_cyc) begin
            @(negedge CLK100MHZ);
            cyc++;
            if (cmd_valid) begin
                got  = 1'b1;
                data = cmd_data;
            end
        end
    endtask

    task automatic count_strobes(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge CLK100MHZ);
            if (cmd_valid) n++;
        end
    endtask

    task automatic test_reset;
        int n;
        CPU_RESETN = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        total++;
        if (cmd_data !== 32'h000F4240) begin bad++; $display("FAIL reset_cmd_data: got %h want 000f4240", cmd_data); end
        total++;
        if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        CPU_RESETN = 1'b1;
        count_strobes(20, n);
        total++;
        if (n != 0) begin bad++; $display("FAIL reset_no_strobe: got %0d strobes want 0", n); end
        total++;
        if (cmd_data !== 32'h000F4240) begin bad++; $display("FAIL reset_hold_data: got %h want 000f4240", cmd_data); end
    endtask

    task automatic test_idle_write;
        int n;
        write(1'b0, 600000);
        count_strobes(10, n);
        total++;
        if (n != 0) begin bad++; $display("FAIL idle_write_strobe: got %0d strobes want 0", n); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_write_busy: got %b want 0", busy); end
    endtask

    task automatic test_ramp_up;
        int unsigned per[5] = '{1000000, 900000, 800000, 700000, 600000};
        int          gap[5] = '{1, 4, 4, 4, 4};
        logic [31:0] d;
        int          c, n;
        bit          g;
        write(1'b1, 600000);
        for (int i = 0; i < 5; i++) begin
            get_strobe(20, d, c, g);
            total++;
            if (!g || d !== word(1'b1, per[i])) begin
                bad++; $display("FAIL ramp_up_data[%0d]: got %h (seen=%0d) want %h", i, d, g, word(1'b1, per[i]));
            end
            total++;
            if (c != gap[i]) begin bad++; $display("FAIL ramp_up_gap[%0d]: got %0d want %0d", i, c, gap[i]); end
            if (i == 0) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL ramp_up_busy: got %b want 1", busy); end
            end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy: got %b want 0", busy); end
        count_strobes(12, n);
        total++;
        if (n != 0) begin bad++; $display("FAIL hold_no_strobe: got %0d want 0", n); end
    endtask

    task automatic test_clamp;
        int unsigned per[4] = '{500000, 400000, 300000, 263158};
        int unsigned back[4] = '{363158, 463158, 563158, 600000};
        int          gap[4] = '{5, 4, 4, 4};
        logic [31:0] d;
        int          c, n;
        bit          g;
        write(1'b1, 100);
        for (int i = 0; i < 4; i++) begin
            get_strobe(20, d, c, g);
            total++;
            if (!g || d !== word(1'b1, per[i])) begin
                bad++; $display("FAIL clamp_data[%0d]: got %h (seen=%0d) want %h", i, d, g, word(1'b1, per[i]));
            end
            total++;
            if (c != gap[i]) begin bad++; $display("FAIL clamp_gap[%0d]: got %0d want %0d", i, c, gap[i]); end
        end
        count_strobes(16, n);
        total++;
        if (n != 0) begin bad++; $display("FAIL clamp_no_strobe: got %0d want 0", n); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL clamp_busy: got %b want 0", busy); end
        write(1'b1, 600000);
        for (int i = 0; i < 4; i++) begin
            get_strobe(20, d, c, g);
            total++;
            if (!g || d !== word(1'b1, back[i])) begin
                bad++; $display("FAIL clamp_back[%0d]: got %h (seen=%0d) want %h", i, d, g, word(1'b1, back[i]));
            end
        end
    endtask

    task automatic test_stop;
        int unsigned per[4] = '{700000, 800000, 900000, 1000000};
        logic [31:0] d;
        int          c, n;
        bit          g;
        write(1'b0, 600000);
        for (int i = 0; i < 4; i++) begin
            get_strobe(20, d, c, g);
            total++;
            if (!g || d !== word(1'b1, per[i])) begin
                bad++; $display("FAIL stop_data[%0d]: got %h (seen=%0d) want %h", i, d, g, word(1'b1, per[i]));
            end
            total++;
            if (c != ((i == 0) ? 5 : 4)) begin bad++; $display("FAIL stop_gap[%0d]: got %0d", i, c); end
        end
        get_strobe(8, d, c, g);
        total++;
        if (!g || d !== 32'h000F4240) begin
            bad++; $display("FAIL stop_final: got %h (seen=%0d) want 000f4240", d, g);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy: got %b want 0", busy); end
        count_strobes(12, n);
        total++;
        if (n != 0) begin bad++; $display("FAIL idle_no_strobe: got %0d want 0", n); end
    endtask

    task automatic test_reversal;
        int unsigned per[9] = '{1000000, 900000, 800000, 700000, 600000, 700000, 800000, 700000, 600000};
        logic [31:0] d;
        int          c;
        bit          g;
        write(1'b1, 600000);
        for (int i = 0; i < 9; i++) begin
            if (i == 5) write(1'b0, 600000);
            if (i == 7) write(1'b1, 600000);
            get_strobe(20, d, c, g);
            total++;
            if (!g || d !== word(1'b1, per[i])) begin
                bad++; $display("FAIL reverse_data[%0d]: got %h (seen=%0d) want %h", i, d, g, word(1'b1, per[i]));
            end
            total++;
            if (d[23:22] !== 2'b11) begin bad++; $display("FAIL reverse_en[%0d]: got %b want 11", i, d[23:22]); end
            if (i == 7) begin
                total++;
                if (c != 5) begin bad++; $display("FAIL reverse_gap: got %0d want 5", c); end
            end
        end
        @(negedge CLK100MHZ);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reverse_hold_busy: got %b want 0", busy); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        int          c, n;
        bit          g;
        write(1'b1, 263158);
        get_strobe(20, d, c, g);
        total++;
        if (!g || d !== word(1'b1, 500000)) begin
            bad++; $display("FAIL areset_pre: got %h (seen=%0d) want %h", d, g, word(1'b1, 500000));
        end
        repeat (2) @(negedge CLK100MHZ);
        #2 CPU_RESETN = 1'b0;
        #1;
        total++;
        if (cmd_data !== 32'h000F4240) begin bad++; $display("FAIL areset_data: got %h want 000f4240", cmd_data); end
        total++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            bad++; $display("FAIL areset_ctrl: got busy=%b valid=%b want 0 0", busy, cmd_valid);
        end
`ifdef STEPPER_RAMP_ECHO_CHECK_EN
        total++;
        if (echo_err !== 1'b0) begin bad++; $display("FAIL areset_echo: got %b want 0", echo_err); end
`endif
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        count_strobes(16, n);
        total++;
        if (n != 0 || busy !== 1'b0) begin bad++; $display("FAIL areset_after: got %0d strobes busy=%b want 0 0", n, busy); end
    endtask

`ifdef STEPPER_RAMP_ECHO_CHECK_EN
    task automatic test_echo;
        logic [31:0] d;
        int          c;
        bit          g;
        total++;
        if (echo_err !== 1'b0) begin bad++; $display("FAIL echo_idle: got %b want 0", echo_err); end
        echo_bad = 1'b1;
        write(1'b1, 900000);
        get_strobe(4, d, c, g);
        total++;
        if (!g || echo_err !== 1'b0) begin bad++; $display("FAIL echo_early: got err=%b seen=%0d want 0 1", echo_err, g); end
        @(negedge CLK100MHZ);
        total++;
        if (echo_err !== 1'b1) begin bad++; $display("FAIL echo_set: got %b want 1", echo_err); end
        echo_bad = 1'b0;
        write(1'b1, 900000);
        total++;
        if (echo_err !== 1'b0) begin bad++; $display("FAIL echo_clear: got %b want 0", echo_err); end
        get_strobe(8, d, c, g);
        @(negedge CLK100MHZ);
        total++;
        if (!g || echo_err !== 1'b0) begin bad++; $display("FAIL echo_good: got err=%b seen=%0d want 0 1", echo_err, g); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_write();
        test_ramp_up();
        test_clamp();
        test_stop();
        test_reversal();
        test_async_reset();
`ifdef STEPPER_RAMP_ECHO_CHECK_EN
        test_echo();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
